// File: rtl/i2c_regfile_slave.sv
// Purpose : I2C slave exposing a bank of 8-bit registers (pointer write, data write, sequential read).
// Latency : bus lines see 2-flop sync (+2 cycles with filter); SDA driven 1 cycle after sync'd SCL fall; host_rdata 1 cycle.
// Backpres: none on the host side; I2C pacing is owned by the master, the slave never stretches SCL.
//
// Ports:
//   clock, reset          - single clock, asynchronous active-low reset
//   sda_in, scl_in        - raw bus line levels
//   sda_oen               - 0 pulls SDA low, 1 releases it (open drain)
//   busy                  - high from an address-matched START until STOP or master NACK
//   wr_strobe/addr/data   - one-cycle pulse per register written over I2C
//   host_addr/host_rdata  - backdoor read port, registered (1 cycle)
// Build option: define I2C_REGFILE_SLAVE_GLITCH_FILTER_EN to insert a 3-sample majority
// filter on each synchronised line.
module i2c_regfile_slave #(
   parameter logic [6:0] CHIP_ADDR = 7'h39,
   parameter int          ADDR_W    = 8,
   parameter int          DEPTH     = 256,
   parameter int          AUTO_INC  = 1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              sda_in,
   input  logic              scl_in,
   output logic              sda_oen,
   output logic              busy,
   output logic              wr_strobe,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [7:0]        wr_data,
   input  logic [ADDR_W-1:0] host_addr,
   output logic [7:0]        host_rdata
);

   typedef enum logic [3:0] {
      IDLE, DEV, DEV_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, MACK, IGNORE
   } state_t;

   localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

   // ---------------------------------------------------------------- line conditioning
   logic [1:0] scl_sync, sda_sync;
   logic       scl_f, sda_f;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         scl_sync <= 2'b11;
         sda_sync <= 2'b11;
      end else begin
         scl_sync <= {scl_sync[0], scl_in};
         sda_sync <= {sda_sync[0], sda_in};
      end
   end

`ifdef I2C_REGFILE_SLAVE_GLITCH_FILTER_EN
   localparam logic [2:0] SETTLE = 3'd6;
   logic [2:0] scl_h, sda_h;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         scl_h <= 3'b111;
         sda_h <= 3'b111;
      end else begin
         scl_h <= {scl_h[1:0], scl_sync[1]};
         sda_h <= {sda_h[1:0], sda_sync[1]};
      end
   end

   // A level change wins only once two of three samples agree: single-cycle pulses vanish.
   assign scl_f = (scl_h[0] & scl_h[1]) | (scl_h[0] & scl_h[2]) | (scl_h[1] & scl_h[2]);
   assign sda_f = (sda_h[0] & sda_h[1]) | (sda_h[0] & sda_h[2]) | (sda_h[1] & sda_h[2]);
`else
   localparam logic [2:0] SETTLE = 3'd3;
   assign scl_f = scl_sync[1];
   assign sda_f = sda_sync[1];
`endif

   // Edges are masked until the pipeline holds real line samples, so the reset value of
   // the flops can never masquerade as a START after reset is released.
   logic [2:0] settle_q;
   logic       scl_q, sda_q, edges_ok;
   logic       scl_rise, scl_fall, start_det, stop_det;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         settle_q <= 3'd0;
         scl_q    <= 1'b1;
         sda_q    <= 1'b1;
      end else begin
         if (settle_q != SETTLE) settle_q <= settle_q + 3'd1;
         scl_q <= scl_f;
         sda_q <= sda_f;
      end
   end

   assign edges_ok  = (settle_q == SETTLE);
   assign scl_rise  = edges_ok &  scl_f & ~scl_q;
   assign scl_fall  = edges_ok & ~scl_f &  scl_q;
   assign start_det = edges_ok &  scl_f &  scl_q & ~sda_f &  sda_q;
   assign stop_det  = edges_ok &  scl_f &  scl_q &  sda_f & ~sda_q;

   // ---------------------------------------------------------------- datapath signals
   state_t            state_q, state_d;
   logic [6:0]        rx_sr;       // first 7 bits of the byte in flight; rx_sr[0] is R/W after DEV
   logic [7:0]        tx_sr;
   logic [3:0]        bit_cnt;     // data states: bits seen; ACK/MACK states: 1 once the ACK clock began
   logic [ADDR_W-1:0] ptr, ptr_inc;
   logic [7:0]        mem [DEPTH];
   logic [7:0]        rx_byte, ptr_rdata, inc_rdata;
   logic              last_bit, addr_match, ptr_in_range, inc_in_range;
   logic              sda_oen_d, busy_d, wr_en;

   assign rx_byte      = {rx_sr, sda_f};
   assign last_bit     = scl_rise && (bit_cnt == 4'd7);
   assign addr_match   = (rx_byte[7:1] == CHIP_ADDR);
   assign ptr_inc      = (AUTO_INC != 0) ? ptr + ADDR_W'(1) : ptr;
   assign ptr_in_range = ({1'b0, ptr} < DEPTH_C);
   assign inc_in_range = ({1'b0, ptr_inc} < DEPTH_C);
   assign ptr_rdata    = ptr_in_range ? mem[ptr] : 8'hFF;
   assign inc_rdata    = inc_in_range ? mem[ptr_inc] : 8'hFF;

   // ---------------------------------------------------------------- FSM: state register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // ---------------------------------------------------------------- FSM: next state
   always_comb begin
      state_d = state_q;
      if (stop_det) begin
         state_d = IDLE;
      end else if (start_det) begin
         state_d = DEV;
      end else begin
         case (state_q)
            DEV:       if (last_bit) state_d = addr_match ? DEV_ACK : IGNORE;
            DEV_ACK:   if (scl_fall && bit_cnt == 4'd1) state_d = rx_sr[0] ? RDATA : PTR;
            PTR:       if (last_bit) state_d = PTR_ACK;
            PTR_ACK:   if (scl_fall && bit_cnt == 4'd1) state_d = WDATA;
            WDATA:     if (last_bit) state_d = WDATA_ACK;
            WDATA_ACK: if (scl_fall && bit_cnt == 4'd1) state_d = WDATA;
            RDATA:     if (scl_fall && bit_cnt == 4'd8) state_d = MACK;
            MACK: begin
               if (scl_rise && sda_f)                     state_d = IGNORE;
               else if (scl_fall && bit_cnt == 4'd1)      state_d = RDATA;
            end
            default:   state_d = state_q;
         endcase
      end
   end

   // ---------------------------------------------------------------- FSM: outputs
   always_comb begin
      sda_oen_d = 1'b1;
      wr_en     = 1'b0;
      if (!(start_det || stop_det)) begin
         case (state_q)
            DEV_ACK, PTR_ACK, WDATA_ACK: begin
               if (scl_fall && bit_cnt == 4'd0)
                  sda_oen_d = 1'b0;
               else if (scl_fall && bit_cnt == 4'd1)
                  // A read address hands straight over to the first data MSB.
                  sda_oen_d = (state_q == DEV_ACK && rx_sr[0]) ? tx_sr[7] : 1'b1;
               else
                  sda_oen_d = sda_oen;
            end
            RDATA: begin
               if (scl_fall) sda_oen_d = (bit_cnt == 4'd8) ? 1'b1 : tx_sr[6];
               else          sda_oen_d = sda_oen;
            end
            MACK:  if (scl_fall && bit_cnt == 4'd1) sda_oen_d = tx_sr[7];
            WDATA: wr_en = last_bit && ptr_in_range;
            default: sda_oen_d = 1'b1;
         endcase
      end
      // Busy survives a repeated START (DEV) but not a fresh one.
      if (state_d == IDLE || state_d == IGNORE) busy_d = 1'b0;
      else if (state_d == DEV)                  busy_d = busy;
      else                                      busy_d = 1'b1;
   end

   // ---------------------------------------------------------------- sequential datapath
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sda_oen   <= 1'b1;
         busy      <= 1'b0;
         wr_strobe <= 1'b0;
         wr_addr   <= '0;
         wr_data   <= 8'h00;
         rx_sr     <= 7'h00;
         tx_sr     <= 8'hFF;
         bit_cnt   <= 4'd0;
         ptr       <= '0;
      end else begin
         sda_oen   <= sda_oen_d;
         busy      <= busy_d;
         wr_strobe <= wr_en;
         if (wr_en) begin
            wr_addr <= ptr;
            wr_data <= rx_byte;
         end
         if (start_det || stop_det) begin
            bit_cnt <= 4'd0;
         end else begin
            case (state_q)
               DEV, PTR, WDATA: begin
                  if (scl_rise) begin
                     rx_sr   <= rx_byte[6:0];
                     bit_cnt <= (bit_cnt == 4'd7) ? 4'd0 : bit_cnt + 4'd1;
                  end
                  if (last_bit) begin
                     if (state_q == DEV && addr_match) tx_sr <= ptr_rdata;
                     if (state_q == PTR)               ptr   <= rx_byte[ADDR_W-1:0];
                     if (state_q == WDATA)             ptr   <= ptr_inc;
                  end
               end
               DEV_ACK, PTR_ACK, WDATA_ACK: begin
                  if (scl_fall) bit_cnt <= (bit_cnt == 4'd0) ? 4'd1 : 4'd0;
               end
               RDATA: begin
                  if (scl_rise) begin
                     bit_cnt <= bit_cnt + 4'd1;
                  end else if (scl_fall) begin
                     if (bit_cnt == 4'd8) bit_cnt <= 4'd0;
                     else                 tx_sr   <= {tx_sr[6:0], 1'b1};
                  end
               end
               MACK: begin
                  if (scl_rise && !sda_f) begin
                     bit_cnt <= 4'd1;
                     ptr     <= ptr_inc;
                     tx_sr   <= inc_rdata;
                  end else if (scl_fall && bit_cnt == 4'd1) begin
                     bit_cnt <= 4'd0;
                  end
               end
               default: bit_cnt <= 4'd0;
            endcase
         end
      end
   end

   // ---------------------------------------------------------------- register file
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= 8'h00;
      end else if (wr_en) begin
         mem[ptr] <= rx_byte;
      end
   end

   // Registered read: a same-cycle I2C write shows up here one cycle later.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)                           host_rdata <= 8'h00;
      else if ({1'b0, host_addr} < DEPTH_C) host_rdata <= mem[host_addr];
      else                                  host_rdata <= 8'hFF;
   end

endmodule

// File: tb/tb_i2c_regfile_slave.sv
module tb_i2c_regfile_slave;
   localparam int Q = 8;   // quarter of an I2C bit, in clock cycles

`ifdef I2C_REGFILE_SLAVE_GLITCH_FILTER_EN
   localparam logic [7:0] GLITCH_EXP = 8'h0F;
`else
   localparam logic [7:0] GLITCH_EXP = 8'h07;   // extra 0 shifted in, last bit lost
`endif

   logic       clock = 1'b0;
   logic       reset;
   logic       sda_m, scl_m, sda_line;
   logic [7:0] host_addr;
   logic       sda_oen, busy, wr_strobe;
   logic [7:0] wr_addr, wr_data, host_rdata;

   always #5 clock = ~clock;
   assign sda_line = sda_m & sda_oen;

   i2c_regfile_slave dut (
      .clock      (clock),
      .reset      (reset),
      .sda_in     (sda_line),
      .scl_in     (scl_m),
      .sda_oen    (sda_oen),
      .busy       (busy),
      .wr_strobe  (wr_strobe),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .host_addr  (host_addr),
      .host_rdata (host_rdata)
   );

   int n_chk  = 0;
   int n_pass = 0;

   // Bus monitor: strobes, backdoor value at the strobe and one cycle later, activity counters.
   logic [15:0] stb_q[$];
   logic [7:0]  pre_q[$];
   logic [7:0]  post_q[$];
   bit          post_pend = 1'b0;
   int          busy_cnt = 0;
   int          oen_low_cnt = 0;

   always @(negedge clock) begin
      if (post_pend) begin
         post_q.push_back(host_rdata);
         post_pend = 1'b0;
      end
      if (wr_strobe === 1'b1) begin
         stb_q.push_back({wr_addr, wr_data});
         pre_q.push_back(host_rdata);
         post_pend = 1'b1;
      end
      if (busy === 1'b1)    busy_cnt++;
      if (sda_oen === 1'b0) oen_low_cnt++;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic wq(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
   endtask

   task automatic i2c_start();
      sda_m = 1'b1; wq(Q);
      scl_m = 1'b1; wq(Q);
      sda_m = 1'b0; wq(Q);
      scl_m = 1'b0;
   endtask

   task automatic i2c_stop();
      wq(Q); sda_m = 1'b0;
      wq(Q); scl_m = 1'b1;
      wq(Q); sda_m = 1'b1;
      wq(Q);
   endtask

   task automatic write_bit(input logic b);
      wq(Q); sda_m = b;
      wq(Q); scl_m = 1'b1;
      wq(2*Q); scl_m = 1'b0;
   endtask

   task automatic read_bit(output logic b);
      wq(Q); sda_m = 1'b1;
      wq(Q); scl_m = 1'b1;
      wq(Q); b = sda_line;
      wq(Q); scl_m = 1'b0;
   endtask

   task automatic write_byte(input logic [7:0] d, output logic ack);
      for (int i = 7; i >= 0; i--) write_bit(d[i]);
      read_bit(ack);
   endtask

   task automatic read_byte(output logic [7:0] d, input logic master_ack);
      for (int i = 7; i >= 0; i--) read_bit(d[i]);
      write_bit(master_ack);
   endtask

   typedef struct {
      logic [7:0] ptr;   // pointer byte, also first write address
      logic [7:0] d0;
      logic [7:0] d1;
      logic [7:0] a1;    // hand-computed address of the second byte
   } vec_t;

   vec_t       vt[3];
   logic [3:0] acks;
   logic       a;
   logic [7:0] d;
   logic [3:0] nib;
   int         base, bcnt, obase, bad;

   initial begin
      vt[0] = '{ptr: 8'h10, d0: 8'hAB, d1: 8'hCD, a1: 8'h11};
      vt[1] = '{ptr: 8'hFF, d0: 8'h11, d1: 8'h22, a1: 8'h00};
      vt[2] = '{ptr: 8'h80, d0: 8'h5A, d1: 8'hA5, a1: 8'h81};

      reset = 1'b0; sda_m = 1'b1; scl_m = 1'b1; host_addr = 8'h10;
      wq(3);
      chk("rst_sda_oen",    {15'd0, sda_oen},   16'h1);
      chk("rst_busy",       {15'd0, busy},      16'h0);
      chk("rst_wr_strobe",  {15'd0, wr_strobe}, 16'h0);
      chk("rst_wr_addr",    {8'd0, wr_addr},    16'h0);
      chk("rst_wr_data",    {8'd0, wr_data},    16'h0);
      chk("rst_host_rdata", {8'd0, host_rdata}, 16'h0);
      reset = 1'b1;
      wq(5);

      // Table: pointer + two data bytes per transaction.
      for (int i = 0; i < 3; i++) begin
         host_addr = vt[i].ptr;
         base = stb_q.size();
         i2c_start();
         write_byte(8'h72, acks[3]);
         write_byte(vt[i].ptr, acks[2]);
         write_byte(vt[i].d0, acks[1]);
         write_byte(vt[i].d1, acks[0]);
         i2c_stop();
         wq(2);
         chk($sformatf("vec%0d_acks", i), {12'd0, acks}, 16'h0);
         chk($sformatf("vec%0d_nstb", i), 16'(stb_q.size() - base), 16'd2);
         if (stb_q.size() >= base + 2) begin
            chk($sformatf("vec%0d_stb0", i), stb_q[base],   {vt[i].ptr, vt[i].d0});
            chk($sformatf("vec%0d_stb1", i), stb_q[base+1], {vt[i].a1,  vt[i].d1});
            chk($sformatf("vec%0d_rd_old", i), {8'd0, pre_q[base]},  16'h00);
            chk($sformatf("vec%0d_rd_new", i), {8'd0, post_q[base]}, {8'd0, vt[i].d0});
         end
         host_addr = vt[i].a1; wq(2);
         chk($sformatf("vec%0d_host_a1", i), {8'd0, host_rdata}, {8'd0, vt[i].d1});
         host_addr = vt[i].ptr; wq(2);
         chk($sformatf("vec%0d_host_a0", i), {8'd0, host_rdata}, {8'd0, vt[i].d0});
      end

      // Combined read with repeated START.
      i2c_start();
      write_byte(8'h72, acks[3]);
      write_byte(8'h10, acks[2]);
      i2c_start();
      write_byte(8'h73, acks[1]);
      chk("comb_acks", {13'd0, acks[3:1]}, 16'h0);
      read_byte(d, 1'b0);
      chk("comb_byte0", {8'd0, d}, 16'h00AB);
      chk("comb_busy_mid", {15'd0, busy}, 16'h1);
      read_byte(d, 1'b1);
      chk("comb_byte1", {8'd0, d}, 16'h00CD);
      wq(Q);
      chk("comb_nack_release", {15'd0, sda_oen}, 16'h1);
      chk("comb_nack_busy", {15'd0, busy}, 16'h0);
      i2c_stop();

      // Pointer persists from a pointer-only write into a separate read.
      i2c_start();
      write_byte(8'h72, acks[1]);
      write_byte(8'h81, acks[0]);
      i2c_stop();
      i2c_start();
      write_byte(8'h73, acks[2]);
      read_byte(d, 1'b1);
      i2c_stop();
      chk("persist_acks", {13'd0, acks[2:0]}, 16'h0);
      chk("persist_byte", {8'd0, d}, 16'h00A5);

      // Foreign address: no ACK anywhere, never busy, nothing written.
      base = stb_q.size(); bcnt = busy_cnt; obase = oen_low_cnt;
      i2c_start();
      write_byte(8'h74, acks[1]);
      write_byte(8'h00, acks[0]);
      i2c_stop();
      chk("wrong_acks", {14'd0, acks[1:0]}, 16'h3);
      chk("wrong_oen_low", 16'(oen_low_cnt - obase), 16'd0);
      chk("wrong_busy", 16'(busy_cnt - bcnt), 16'd0);
      chk("wrong_nstb", 16'(stb_q.size() - base), 16'd0);

      // One-cycle SCL glitch while writing 0x0F to 0x40.
      i2c_start();
      write_byte(8'h72, a);
      write_byte(8'h40, a);
      base = stb_q.size();
      for (int i = 7; i >= 4; i--) write_bit(1'b0);
      wq(2); scl_m = 1'b1;
      wq(1); scl_m = 1'b0;
      for (int i = 3; i >= 0; i--) write_bit(1'b1);
      read_bit(a);
      i2c_stop();
      wq(2);
      chk("glitch_nstb", 16'(stb_q.size() - base), 16'd1);
      if (stb_q.size() > base) chk("glitch_stb", stb_q[base], {8'h40, GLITCH_EXP});

      // Reset in the middle of a read byte (reg[0x00] = 0x22, bit 3 is 0).
      i2c_start();
      write_byte(8'h72, acks[1]);
      write_byte(8'h00, acks[0]);
      i2c_stop();
      i2c_start();
      write_byte(8'h73, acks[2]);
      chk("rmid_acks", {13'd0, acks[2:0]}, 16'h0);
      for (int i = 3; i >= 0; i--) read_bit(nib[i]);
      chk("rmid_bits", {12'd0, nib}, 16'h2);
      wq(Q);
      chk("rmid_driving", {15'd0, sda_oen}, 16'h0);
      #2 reset = 1'b0;
      #1;
      chk("rmid_async_release", {15'd0, sda_oen}, 16'h1);
      chk("rmid_busy", {15'd0, busy}, 16'h0);
      chk("rmid_host_rdata", {8'd0, host_rdata}, 16'h0);
      @(negedge clock);
      scl_m = 1'b1; sda_m = 1'b1;
      wq(4);
      reset = 1'b1;
      wq(6);
      // No START yet: a full address byte must be ignored.
      scl_m = 1'b0;
      write_byte(8'h72, a);
      chk("post_rst_ignore", {15'd0, a}, 16'h1);
      i2c_stop();
      i2c_start();
      write_byte(8'h72, acks[2]);
      write_byte(8'h05, acks[1]);
      write_byte(8'h5A, acks[0]);
      i2c_stop();
      chk("post_rst_acks", {13'd0, acks[2:0]}, 16'h0);
      bad = 0;
      for (int i = 0; i < 256; i++) begin
         host_addr = 8'(i);
         wq(2);
         if (host_rdata !== ((i == 5) ? 8'h5A : 8'h00)) bad++;
         if (i == 5) chk("post_rst_reg05", {8'd0, host_rdata}, 16'h005A);
      end
      chk("post_rst_regs_bad", 16'(bad), 16'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
